// File: rtl/seq_divider_if.sv
// Operand/result bundle for seq_divider: a start/busy/done request channel plus
// the registered quotient, remainder and divide-by-zero results.
interface seq_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       busy;
    logic       done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, div_by_zero, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock,
// MSB first; divide-by-zero short-circuits straight to DONE with FF/0/flag.
module seq_divider (
    input  logic                clk,
    input  logic                rst,
    seq_divider_if.slave        bus,
    output logic [1:0]          state_dbg
);
    // Handshake: start is taken only on an edge where busy is low (IDLE); operands
    // are sampled on that edge alone. busy stays high until done, which pulses for
    // exactly one cycle with results valid then and held until the next done.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] d_reg;
    logic [3:0] v_reg;
    logic [3:0] r_reg;
    logic [7:0] wq_reg;
    logic [2:0] cnt;

    logic [4:0] trial;
    logic       q_bit;
    logic [3:0] r_next;

    assign state_dbg = state;

    // The difference always fits in 4 bits because the restored remainder stays below V.
    always_comb begin
        trial  = {r_reg, d_reg[7]};
        q_bit  = (trial >= {1'b0, v_reg});
        r_next = q_bit ? (trial[3:0] - v_reg) : trial[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            d_reg           <= '0;
            v_reg           <= '0;
            r_reg           <= '0;
            wq_reg          <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.divisor != 4'd0) begin
                            d_reg  <= bus.dividend;
                            v_reg  <= bus.divisor;
                            r_reg  <= '0;
                            wq_reg <= '0;
                            cnt    <= '0;
                            state  <= RUN;
                        end else begin
                            bus.quotient    <= 8'hFF;
                            bus.remainder   <= 4'd0;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                RUN: begin
                    d_reg  <= {d_reg[6:0], 1'b0};
                    r_reg  <= r_next;
                    wq_reg <= {wq_reg[6:0], q_bit};
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        bus.quotient    <= {wq_reg[6:0], q_bit};
                        bus.remainder   <= r_next;
                        bus.div_by_zero <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, handshake corner cases and
// a shuffled exhaustive operand sweep scored against an arithmetic reference.
module tb_seq_divider;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_errors;
    logic [12:0] exp_q[$];
    int         idx[4096];

    seq_divider_if dif();

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (dif.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        int q;
        int r;
        if (b == 4'd0) return {1'b1, 8'hFF, 4'h0};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {1'b0, q[7:0], r[3:0]};
    endfunction

    function automatic logic [12:0] observed();
        return {dif.div_by_zero, dif.quotient, dif.remainder};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        dif.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One operation with a one-cycle start; checks busy/done each cycle, result
    // on done, old result held while running, and idle afterwards.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b);
        int          lat;
        logic [12:0] prev;
        logic [12:0] exp;
        lat = (b == 4'd0) ? 1 : 9;
        @(posedge clk); #1;
        prev = observed();
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        dif.start    = 1'b0;
        dif.dividend = 8'($urandom);
        dif.divisor  = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check("busy", 32'(dif.busy), 32'd1);
            check("done", 32'(dif.done), 32'(k == lat));
            if (k < lat) check("hold", 32'(observed()), 32'(prev));
        end
        exp = exp_q.pop_front();
        check($sformatf("result %0d/%0d", a, b), 32'(observed()), 32'(exp));
        @(negedge clk);
        check("idle_busy", 32'(dif.busy), 32'd0);
        check("idle_done", 32'(dif.done), 32'd0);
    endtask

    initial begin
        logic [7:0] bnd_a[6];
        logic [3:0] bnd_b[6];
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        do_reset();

        check("rst_q", 32'(dif.quotient), 32'd0);
        check("rst_r", 32'(dif.remainder), 32'd0);
        check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_done", 32'(dif.done), 32'd0);

        run_op(8'd200, 4'd7);

        bnd_a = '{8'd255, 8'd255, 8'd15, 8'd5, 8'd0, 8'd128};
        bnd_b = '{4'd1, 4'd15, 4'd15, 4'd9, 4'd3, 4'd2};
        for (int i = 0; i < 6; i++) run_op(bnd_a[i], bnd_b[i]);

        run_op(8'd77, 4'd0);
        run_op(8'd77, 4'd5);

        // reset mid-run abandons the operation and clears outputs
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            dif.start    = (k == 0);
            dif.dividend = 8'd200;
            dif.divisor  = 4'd7;
            rst          = (k == 5);
            @(negedge clk);
            if (k > 0) begin
                check("abort_done", 32'(dif.done), 32'd0);
                check("abort_busy", 32'(dif.busy), 32'(k <= 5));
            end
            if (k == 4) check("abort_hold", 32'(observed()), 32'(model(8'd77, 4'd5)));
            if (k == 6) check("abort_clear", 32'(observed()), 32'd0);
        end
        run_op(8'd9, 4'd2);

        // a start pulse during RUN is ignored
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            dif.start    = (k == 0) || (k == 4);
            dif.dividend = (k == 0) ? 8'd100 : 8'd50;
            dif.divisor  = (k == 0) ? 4'd3 : 4'd5;
            @(negedge clk);
            if (k > 0) check("pulse_done", 32'(dif.done), 32'(k == 9));
            if (k == 9) check("pulse_result", 32'(observed()), 32'(model(8'd100, 4'd3)));
            if (k >= 10) check("pulse_busy", 32'(dif.busy), 32'd0);
        end

        // held start gives one result every 10 cycles
        for (int k = 0; k <= 29; k++) begin
            @(posedge clk); #1;
            dif.start    = 1'b1;
            dif.dividend = 8'd20 + 8'(k / 10);
            dif.divisor  = 4'd3;
            @(negedge clk);
            if (k > 0) check("held_done", 32'(dif.done), 32'((k % 10) == 9));
            if ((k % 10) == 9)
                check("held_result", 32'(observed()), 32'(model(8'd20 + 8'(k / 10), 4'd3)));
        end
        @(posedge clk); #1;
        dif.start = 1'b0;
        @(negedge clk);
        check("held_stop", 32'(dif.busy), 32'd0);

        // shuffled exhaustive sweep
        for (int i = 0; i < 4096; i++) idx[i] = i;
        for (int i = 4095; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = idx[i];
            idx[i] = idx[j];
            idx[j] = t;
        end
        for (int i = 0; i < 4096; i++) run_op(8'(idx[i] >> 4), 4'(idx[i]));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
